// File: rtl/iq_power_pkg.sv
// rtl/iq_power_pkg.sv - shared state encoding and widths for the I/Q power sequencer
package iq_power_pkg;

    localparam int IQ_W       = 16;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        EMIT    = 2'd2,
        WAIT_DS = 2'd3
    } iq_power_state_t;

endpackage

// File: rtl/serial_sq_acc.sv
// rtl/serial_sq_acc.sv - W-bit unsigned bit-serial squarer, one multiplier bit per step
module serial_sq_acc #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [W-1:0]     operand,
    output logic [2*W-1:0]   product
);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;

    // Multiplicand shifts left while the multiplier shifts right, LSB first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            mcand  <= {{W{1'b0}}, operand};
            mplier <= operand;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = acc;

endmodule

// File: rtl/iq_power_seq.sv
// rtl/iq_power_seq.sv - I^2+Q^2 radicand feeder for the serial sqrt stage; IQ_POWER_DROP_CNT_EN adds drop_cnt
module iq_power_seq
    import iq_power_pkg::*;
#(
    parameter int W = IQ_W,
    parameter int N = 2 * IQ_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_i,
    input  logic [W-1:0] in_q,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_num,
    output logic         out_valid,
    input  logic         ds_done
`ifdef IQ_POWER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    if (N != 2 * W) begin : g_bad_n
        $error("iq_power_seq: N must equal 2*W");
    end
    if ((W < 4) || ((W % 2) != 0)) begin : g_bad_w
        $error("iq_power_seq: W must be even and >= 4");
    end

    localparam int                CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W);
    localparam logic [W-1:0]      ONE_W    = {{(W-1){1'b0}}, 1'b1};

    iq_power_state_t  state;
    iq_power_state_t  state_next;
    logic [CNT_W-1:0] cnt;
    logic             acc_start;
    logic             acc_step;
    logic [W-1:0]     abs_i;
    logic [W-1:0]     abs_q;
    logic [N-1:0]     prod_i;
    logic [N-1:0]     prod_q;

    // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact as unsigned.
    assign abs_i = in_i[W-1] ? (~in_i + ONE_W) : in_i;
    assign abs_q = in_q[W-1] ? (~in_q + ONE_W) : in_q;

    serial_sq_acc #(.W(W)) u_sq_i (
        .clk     (clk),
        .reset   (reset),
        .start   (acc_start),
        .step    (acc_step),
        .operand (abs_i),
        .product (prod_i)
    );

    serial_sq_acc #(.W(W)) u_sq_q (
        .clk     (clk),
        .reset   (reset),
        .start   (acc_start),
        .step    (acc_step),
        .operand (abs_q),
        .product (prod_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last MUL cycle (cnt == W) is spent on the registered final add.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        acc_start  = 1'b0;
        acc_step   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_start  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (cnt == CNT_LAST) begin
                    state_next = EMIT;
                end else begin
                    acc_step = 1'b1;
                end
            end
            EMIT: begin
                out_valid  = 1'b1;
                state_next = WAIT_DS;
            end
            WAIT_DS: begin
                if (ds_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            out_num <= '0;
        end else begin
            if (acc_start) begin
                cnt <= '0;
            end else if (acc_step) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == MUL) && (state_next == EMIT)) begin
                out_num <= prod_i + prod_q;
            end
        end
    end

`ifdef IQ_POWER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
